// File: rtl/poly_bank_loader.sv
// poly_bank_loader: streams N coefficients, reduces them mod Q and writes them into four radix-4 conflict-free banks
module poly_bank_loader #(
  parameter int DATA_WIDTH = 14,
  parameter int Q          = 12289,
  parameter int N          = 1024,
  parameter int LOGN       = 10,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [3:0]            bank_we,
  output logic [ADDR_W-1:0]     bank_addr,
  output logic [DATA_WIDTH-1:0] bank_din,
  output logic                  ntt_start,
  output logic                  busy,
  output logic                  range_err
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, START} state_t;
  localparam logic [DATA_WIDTH-1:0] QV = DATA_WIDTH'(Q);
  state_t                state_q, state_d;
  logic [LOGN-1:0]       count_q, count_d;
  logic [3:0]            we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  rerr_q, rerr_d;
  logic                  hs, over;
  logic [1:0]            bank;
  // bank is the base-4 digit sum of the accept index, wrapping mod 4
  always_comb begin
    bank = '0;
    for (int k = 0; k < LOGN / 2; k++) bank = bank + count_q[2*k +: 2];
  end
  // next-state, handshake and registered write-port inputs
  always_comb begin
    in_ready = state_q == LOAD;
    hs       = in_valid & in_ready;
    over     = in_data >= QV;
    state_d  = state_q;
    count_d  = count_q;
    busy_d   = busy_q;
    rerr_d   = rerr_q;
    case (state_q)
      IDLE: if (load_start) begin
        state_d = LOAD;
        count_d = '0;
        rerr_d  = 1'b0;
        busy_d  = 1'b1;
      end
      LOAD: if (hs) begin
        if (count_q == LOGN'(N - 1)) state_d = FLUSH;
        else count_d = count_q + 1'b1;
        if (over) rerr_d = 1'b1;
      end
      FLUSH: state_d = START;
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    we_d   = hs ? 4'b0001 << bank : 4'b0000;
    addr_d = hs ? ADDR_W'(count_q[LOGN-1:2]) : addr_q;
    din_d  = hs ? (over ? in_data - QV : in_data) : din_q;
  end
  // state and write-port registers, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      rerr_q  <= rerr_d;
    end
  end
  assign bank_we   = we_q;
  assign bank_addr = addr_q;
  assign bank_din  = din_q;
  assign busy      = busy_q;
  assign range_err = rerr_q;
  assign ntt_start = state_q == START;
endmodule
